// File: rtl/instr_encoder_if.sv
// Bus bundle for instr_encoder: session control, instruction fields, IMEM write port and status.
interface instr_encoder_if;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned COUNT_W = 11;

    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic [REG_W-1:0]   mnem;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   shamt;
    logic [IMM_W-1:0]   imm;
    logic [TGT_W-1:0]   target;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WORD_W-1:0]  mem_wdata;
    logic [COUNT_W-1:0] count;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, base_addr, in_valid, in_last, mnem, rs, rt, rd, shamt, imm, target,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );

    modport slave (
        input  start, base_addr, in_valid, in_last, mnem, rs, rt, rd, shamt, imm, target,
        output in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
    );
endinterface

// File: rtl/instr_encoder.sv
// MIPS-subset instruction encoder streaming encoded words into IMEM in load sessions.
// Optional macro ENC_ILLEGAL_CHECK_EN: reject illegal mnemonics (set err, no write) instead of writing a nop.
module instr_encoder (
    input  logic              clk,
    input  logic              rst,
    instr_encoder_if.slave    bus
);
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned TGT_W   = 26;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned COUNT_W = 11;
    localparam int unsigned OP_W    = 6;
    localparam logic [COUNT_W-1:0] LAST_SLOT = COUNT_W'(1023);

`ifdef ENC_ILLEGAL_CHECK_EN
    localparam bit ILLEGAL_CHECK = 1'b1;
`else
    localparam bit ILLEGAL_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_in_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic [COUNT_W-1:0]  r_count;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W-1:0]   r_base;

    logic                w_xfer;
    logic                w_write;
    logic                w_illegal;
    logic                w_legal;
    logic [WORD_W-1:0]   w_word;

    function automatic logic [WORD_W-1:0] r_word(input logic [OP_W-1:0] funct,
                                                 input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                                 input logic [REG_W-1:0] rd, input logic [REG_W-1:0] sh);
        return {OP_W'(0), rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [WORD_W-1:0] i_word(input logic [OP_W-1:0] op, input logic [REG_W-1:0] rs,
                                                 input logic [REG_W-1:0] rt, input logic [IMM_W-1:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [WORD_W-1:0] j_word(input logic [OP_W-1:0] op, input logic [TGT_W-1:0] tgt);
        return {op, tgt};
    endfunction

    // Mnemonic decode: field forcing for shifts, jr, syscall and bltz is folded in here
    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        case (bus.mnem)
            5'd0:  w_word = r_word(6'h20, bus.rs, bus.rt, bus.rd, 5'd0);
            5'd1:  w_word = r_word(6'h21, bus.rs, bus.rt, bus.rd, 5'd0);
            5'd2:  w_word = r_word(6'h22, bus.rs, bus.rt, bus.rd, 5'd0);
            5'd3:  w_word = r_word(6'h24, bus.rs, bus.rt, bus.rd, 5'd0);
            5'd4:  w_word = r_word(6'h25, bus.rs, bus.rt, bus.rd, 5'd0);
            5'd5:  w_word = r_word(6'h27, bus.rs, bus.rt, bus.rd, 5'd0);
            5'd6:  w_word = r_word(6'h2A, bus.rs, bus.rt, bus.rd, 5'd0);
            5'd7:  w_word = r_word(6'h2B, bus.rs, bus.rt, bus.rd, 5'd0);
            5'd8:  w_word = r_word(6'h00, 5'd0, bus.rt, bus.rd, bus.shamt);
            5'd9:  w_word = r_word(6'h02, 5'd0, bus.rt, bus.rd, bus.shamt);
            5'd10: w_word = r_word(6'h03, 5'd0, bus.rt, bus.rd, bus.shamt);
            5'd11: w_word = r_word(6'h08, bus.rs, 5'd0, 5'd0, 5'd0);
            5'd12: w_word = r_word(6'h0C, 5'd0, 5'd0, 5'd0, 5'd0);
            5'd13: w_word = i_word(6'h08, bus.rs, bus.rt, bus.imm);
            5'd14: w_word = i_word(6'h09, bus.rs, bus.rt, bus.imm);
            5'd15: w_word = i_word(6'h0A, bus.rs, bus.rt, bus.imm);
            5'd16: w_word = i_word(6'h0B, bus.rs, bus.rt, bus.imm);
            5'd17: w_word = i_word(6'h0C, bus.rs, bus.rt, bus.imm);
            5'd18: w_word = i_word(6'h0D, bus.rs, bus.rt, bus.imm);
            5'd19: w_word = i_word(6'h0E, bus.rs, bus.rt, bus.imm);
            5'd20: w_word = i_word(6'h23, bus.rs, bus.rt, bus.imm);
            5'd21: w_word = i_word(6'h21, bus.rs, bus.rt, bus.imm);
            5'd22: w_word = i_word(6'h2B, bus.rs, bus.rt, bus.imm);
            5'd23: w_word = i_word(6'h04, bus.rs, bus.rt, bus.imm);
            5'd24: w_word = i_word(6'h05, bus.rs, bus.rt, bus.imm);
            5'd25: w_word = i_word(6'h01, bus.rs, 5'd0, bus.imm);
            5'd26: w_word = j_word(6'h02, bus.target);
            5'd27: w_word = j_word(6'h03, bus.target);
            default: begin
                w_legal = 1'b0;
                w_word  = '0;
            end
        endcase
    end

    assign w_xfer    = bus.in_valid && r_in_ready && (r_state == S_RUN);
    assign w_write   = w_xfer && (w_legal || !ILLEGAL_CHECK);
    assign w_illegal = w_xfer && !w_legal && ILLEGAL_CHECK;

    // Next-state logic; FULL is entered when the 1024th word is written without in_last
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_state_next = S_RUN;
            S_RUN: begin
                if (w_xfer && bus.in_last)
                    w_state_next = S_DONE;
                else if (w_write && (r_count == LAST_SLOT))
                    w_state_next = S_FULL;
            end
            S_FULL:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_base      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == S_RUN);
            r_busy     <= (w_state_next != S_IDLE);
            r_done     <= (w_state_next == S_DONE);
            r_mem_we   <= w_write;
            if (w_write) begin
                r_mem_addr  <= ADDR_W'(r_base + r_count[ADDR_W-1:0]);
                r_mem_wdata <= w_word;
                r_count     <= COUNT_W'(r_count + COUNT_W'(1));
            end
            if ((r_state == S_IDLE) && bus.start) begin
                r_base  <= bus.base_addr;
                r_count <= '0;
                r_err   <= 1'b0;
            end
            if (((r_state == S_FULL) && bus.in_valid) || w_illegal)
                r_err <= 1'b1;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.count     = r_count;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed encodings.
module tb_instr_encoder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                             input logic [25:0] tgt, input logic last);
        bus.mnem     = mn;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.rd       = rd;
        bus.shamt    = sh;
        bus.imm      = imm;
        bus.target   = tgt;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
    endtask

    task automatic check_write(input string tag, input logic [9:0] addr, input logic [31:0] data,
                               input logic [10:0] cnt);
        check({tag, "_we"},   32'(bus.mem_we), 32'd1);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'(addr));
        check({tag, "_data"}, bus.mem_wdata, data);
        check({tag, "_cnt"},  32'(bus.count), 32'(cnt));
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rdy"},  32'(bus.in_ready), 32'd0);
        check({tag, "_we"},   32'(bus.mem_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        check({tag, "_data"}, bus.mem_wdata, 32'd0);
        check({tag, "_cnt"},  32'(bus.count), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_err"},  32'(bus.err), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        set_instr(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");

        // Session A: start with in_valid already high must not accept that cycle
        rst = 1'b0;
        bus.start = 1'b1;
        bus.base_addr = 10'd0;
        set_instr(5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 16'h1234, 26'd0, 1'b0);
        tick();
        bus.start = 1'b0;
        check("a_start_we",   32'(bus.mem_we), 32'd0);
        check("a_start_cnt",  32'(bus.count), 32'd0);
        check("a_start_rdy",  32'(bus.in_ready), 32'd1);
        check("a_start_busy", 32'(bus.busy), 32'd1);
        tick();
        check_write("a_add", 10'd0, 32'h00221820, 11'd1);
        set_instr(5'd2, 5'd2, 5'd3, 5'd1, 5'd0, 16'd0, 26'd0, 1'b0);
        tick();
        check_write("a_sub", 10'd1, 32'h00430822, 11'd2);
        bus.in_valid = 1'b0;
        tick();
        check("a_gap_we", 32'(bus.mem_we), 32'd0);
        bus.start = 1'b1;
        bus.base_addr = 10'd500;
        tick();
        bus.start = 1'b0;
        check("a_rstart_we",  32'(bus.mem_we), 32'd0);
        check("a_rstart_rdy", 32'(bus.in_ready), 32'd1);
        set_instr(5'd11, 5'd31, 5'd5, 5'd6, 5'd2, 16'hFFFF, 26'd0, 1'b0);
        tick();
        check_write("a_jr", 10'd2, 32'h03E00008, 11'd3);
        set_instr(5'd8, 5'd7, 5'd2, 5'd4, 5'd3, 16'd0, 26'd0, 1'b0);
        tick();
        check_write("a_sll", 10'd3, 32'h000220C0, 11'd4);
        set_instr(5'd12, 5'd9, 5'd10, 5'd11, 5'd12, 16'hABCD, 26'h3FFFFFF, 1'b0);
        tick();
        check_write("a_syscall", 10'd4, 32'h0000000C, 11'd5);
        set_instr(5'd25, 5'd4, 5'd9, 5'd1, 5'd0, 16'h0010, 26'd0, 1'b0);
        tick();
        check_write("a_bltz", 10'd5, 32'h04800010, 11'd6);
        set_instr(5'd20, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b0);
        tick();
        check_write("a_lw", 10'd6, 32'h8FA80004, 11'd7);
        set_instr(5'd30, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'h1, 1'b1);
        tick();
`ifdef ENC_ILLEGAL_CHECK_EN
        check("a_ill_we",  32'(bus.mem_we), 32'd0);
        check("a_ill_cnt", 32'(bus.count), 32'd7);
        check("a_ill_err", 32'(bus.err), 32'd1);
`else
        check_write("a_ill", 10'd7, 32'h00000000, 11'd8);
        check("a_ill_err", 32'(bus.err), 32'd0);
`endif
        check("a_done",      32'(bus.done), 32'd1);
        check("a_done_busy", 32'(bus.busy), 32'd1);
        check("a_done_rdy",  32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick();
        check("a_post_done", 32'(bus.done), 32'd0);
        check("a_post_busy", 32'(bus.busy), 32'd0);
        check("a_post_we",   32'(bus.mem_we), 32'd0);
`ifdef ENC_ILLEGAL_CHECK_EN
        check("a_post_cnt", 32'(bus.count), 32'd7);
        check("a_post_err", 32'(bus.err), 32'd1);
`else
        check("a_post_cnt", 32'(bus.count), 32'd8);
        check("a_post_err", 32'(bus.err), 32'd0);
`endif

        // Session B: addi then j with in_last
        bus.start = 1'b1;
        bus.base_addr = 10'd0;
        tick();
        bus.start = 1'b0;
        check("b_start_cnt", 32'(bus.count), 32'd0);
        check("b_start_err", 32'(bus.err), 32'd0);
        set_instr(5'd13, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b0);
        tick();
        check_write("b_addi", 10'd0, 32'h2005FFFF, 11'd1);
        check("b_addi_done", 32'(bus.done), 32'd0);
        set_instr(5'd26, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100, 1'b1);
        tick();
        check_write("b_j", 10'd1, 32'h08000100, 11'd2);
        check("b_done", 32'(bus.done), 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick();
        check("b_post_done", 32'(bus.done), 32'd0);
        check("b_post_cnt",  32'(bus.count), 32'd2);

        // Session C: address wrap from base 1022 and saturation into FULL
        bus.start = 1'b1;
        bus.base_addr = 10'd1022;
        tick();
        bus.start = 1'b0;
        set_instr(5'd18, 5'd0, 5'd1, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        for (int i = 0; i < 1024; i++) begin
            bus.imm = 16'(i);
            tick();
            check("c_we",   32'(bus.mem_we), 32'd1);
            check("c_addr", 32'(bus.mem_addr), 32'((1022 + i) % 1024));
            check("c_data", bus.mem_wdata, 32'h34010000 | 32'(i));
        end
        check("c_full_cnt",  32'(bus.count), 32'd1024);
        check("c_full_rdy",  32'(bus.in_ready), 32'd0);
        check("c_full_busy", 32'(bus.busy), 32'd1);
        check("c_full_done", 32'(bus.done), 32'd0);
        check("c_full_err",  32'(bus.err), 32'd0);
        tick();
        check("c_ovf_err",  32'(bus.err), 32'd1);
        check("c_ovf_done", 32'(bus.done), 32'd1);
        check("c_ovf_we",   32'(bus.mem_we), 32'd0);
        check("c_ovf_cnt",  32'(bus.count), 32'd1024);
        bus.in_valid = 1'b0;
        tick();
        check("c_end_done", 32'(bus.done), 32'd0);
        check("c_end_busy", 32'(bus.busy), 32'd0);
        check("c_end_cnt",  32'(bus.count), 32'd1024);
        check("c_end_err",  32'(bus.err), 32'd1);

        // Session D: reset mid-session with a transfer pending
        bus.start = 1'b1;
        bus.base_addr = 10'd3;
        tick();
        bus.start = 1'b0;
        check("d_run_rdy", 32'(bus.in_ready), 32'd1);
        set_instr(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0, 26'd0, 1'b0);
        rst = 1'b1;
        tick();
        check_idle_zero("d_rst");
        rst = 1'b0;
        tick();
        check("d_after_we",   32'(bus.mem_we), 32'd0);
        check("d_after_busy", 32'(bus.busy), 32'd0);
        check("d_after_rdy",  32'(bus.in_ready), 32'd0);
        check("d_after_cnt",  32'(bus.count), 32'd0);
        bus.in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
